dct_block_sequencer: RTL and testbench
======================================

# dct_block_sequencer

Frame-level controller for the 8x8 DCT core in the image-compression pipeline. It walks a raster image held in pixel memory block by block and level-shifts each 8x8 block into the DCT input buffer. It then starts the transform, waits for completion, and streams the 64 coefficients out in zig-zag order to the quantiser/entropy stage under valid/ready backpressure.

## Interface
- IMG_W, 256, image width in pixels; must be a multiple of 8.
- IMG_H, 256, image height in pixels; must be a multiple of 8.
- ADDR_W, 16, pixel-memory address width; 2^ADDR_W ≥ IMG_W·IMG_H.
- PIX_W, 8, unsigned pixel width.
- COEF_W, 12, signed DCT coefficient width.

Ports:
- clk  in  1  system clock; single clock domain, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame; ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until frame_done.
- frame_done  out  1  one-cycle pulse after the last coefficient of the last block is accepted.
- mem_addr  out  ADDR_W  pixel read address.
- mem_rd  out  1  read strobe; mem_data is valid exactly 1 cycle later.
- mem_data  in  PIX_W  pixel read data.
- dct_load  out  1  write strobe into the DCT input buffer.
- dct_load_idx  out  6  raster index in the block, row·8+col.
- dct_sample  out  PIX_W+1  signed sample, mem_data − 2^(PIX_W−1).
- dct_start  out  1  one-cycle transform start.
- dct_done  in  1  one-cycle completion from the DCT.
- coef_rd  out  1  coefficient read strobe; coef_data is valid 1 cycle later.
- coef_idx  out  6  raster index of the coefficient read.
- coef_data  in  COEF_W  coefficient read data.
- out_valid  out  1  output coefficient valid.
- out_ready  in  1  downstream ready.
- out_data  out  COEF_W  coefficient, zig-zag order.
- out_last  out  1  high with the 64th coefficient of each block.

## Operation
- FSM states: IDLE, FETCH, TAIL, KICK, WAIT, DRAIN, NEXT.
- IDLE → FETCH on start. Block counters bx and by reset to 0.
- FETCH: issue 64 consecutive reads, one per cycle, raster order inside the block.
  - Address: mem_addr = (by·8+r)·IMG_W + bx·8 + c.
  - Each read returns in the following cycle. That cycle asserts dct_load with the idx of the read and the level-shifted sample.
  - After the 64th read → TAIL. TAIL is one cycle that performs the last load, then → KICK.
- KICK: dct_start=1 for one cycle → WAIT.
- WAIT: on dct_done → DRAIN.
- DRAIN: read coefficients in zig-zag order k=0..63, with coef_idx = ZZ[k].
  - Results enter a 2-entry output FIFO.
  - coef_rd is asserted only when FIFO occupancy + in-flight reads < 2.
  - With out_ready held at 1, sustained throughput is one coefficient per cycle.
  - out_last is set on k=63.
  - DRAIN → NEXT when the k=63 word is accepted (out_valid & out_ready).
- NEXT: advance bx. When bx wraps from IMG_W/8−1 to 0, advance by.
  - If the finished block was the last one (bx=IMG_W/8−1, by=IMG_H/8−1): pulse frame_done and → IDLE.
  - Otherwise → FETCH.
- start pulses during busy are dropped. They are not queued.
- A dct_done seen outside WAIT is ignored.
- rst at any cycle, including mid-frame, forces the following within one edge:
  - state returns to IDLE, FIFO is emptied, in-flight reads are discarded.
  - No partial block is emitted afterward.

## Timing
- Reset values: busy, frame_done, mem_rd, dct_load, dct_start, coef_rd, out_valid and out_last are all 0. mem_addr, dct_load_idx, dct_sample, coef_idx and out_data are 0.
- start accepted at cycle t:
  - first mem_rd at t+1;
  - first dct_load at t+2;
  - dct_start at t+66.
- dct_done at cycle d gives the first coef_rd at d+1 and the first out_valid at d+2.
- out_data/out_valid/out_last hold stable while out_valid & !out_ready.
- Per-block overhead beyond DCT latency, with no backpressure: 64 load + 2 (TAIL, KICK) + 1 (WAIT exit) + 65 drain + 1 (NEXT) cycles.

## Structure
- Shared package/header dct_pkg holds:
  - the FSM state encoding;
  - the 64-entry zig-zag table ZZ;
  - BLK=8;
  - COEF_W defaults.
- One sub-module: zigzag_rom, a combinational 6-bit in / 6-bit out table lookup, also reused by the decoder.
- The output FIFO stays inline in this module (2 entries, occupancy counter).

## Test plan
- 8x8 image with pixel = raster index, mock DCT returning coef[i] = i after 5 cycles → loads show samples −128..−65 at idx 0..63; outputs are 0,1,8,16,9,2,... ending at 63 with out_last; frame_done once.
- 16x16 image, constant pixels → mem_addr for block (1,1) starts at 136 and row-steps by 16; four out_last pulses; frame_done after the 4th.
- out_ready toggling 1,0,0,1 during DRAIN → no lost or duplicated coefficients, data stable while stalled, FIFO never exceeds 2.
- rst asserted at load 30 of block 2 → all outputs 0 next cycle; a new start gives a clean frame beginning at address 0.
- start re-pulsed during WAIT, plus a spurious dct_done during FETCH → no effect; sequence and counts identical to the baseline run.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared definitions for the DCT block sequencer: FSM encoding,
// block geometry and the zig-zag scan table.
package dct_pkg;

    localparam int BLK        = 8;
    localparam int BLK_N      = BLK * BLK;
    localparam int PIX_W_DEF  = 8;
    localparam int COEF_W_DEF = 12;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        TAIL,
        KICK,
        WAIT,
        DRAIN,
        NEXT
    } state_t;

    // Entry k is the raster index (row*8+col) of the k-th zig-zag coefficient.
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

// File: rtl/zigzag_rom.sv
// Zig-zag scan position to raster index lookup.
// Purely combinational; shared with the decoder side.
module zigzag_rom
    import dct_pkg::*;
(
    input  logic [5:0] k,
    output logic [5:0] idx
);

    assign idx = ZZ[k];

endmodule

// File: rtl/dct_block_sequencer.sv
// Frame controller: fetches 8x8 pixel blocks into the DCT, runs it,
// and streams coefficients out in zig-zag order through a 2-entry FIFO.
module dct_block_sequencer
    import dct_pkg::*;
#(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 16,
    parameter int PIX_W  = PIX_W_DEF,
    parameter int COEF_W = COEF_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     frame_done,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_rd,
    input  logic [PIX_W-1:0]         mem_data,
    output logic                     dct_load,
    output logic [5:0]               dct_load_idx,
    output logic signed [PIX_W:0]    dct_sample,
    output logic                     dct_start,
    input  logic                     dct_done,
    output logic                     coef_rd,
    output logic [5:0]               coef_idx,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [COEF_W-1:0] out_data,
    output logic                     out_last
);

    localparam int BX_N = IMG_W / BLK;
    localparam int BY_N = IMG_H / BLK;
    localparam int BXW  = (BX_N > 1) ? $clog2(BX_N) : 1;
    localparam int BYW  = (BY_N > 1) ? $clog2(BY_N) : 1;
    localparam logic [PIX_W:0] MID = {2'b01, {(PIX_W-1){1'b0}}};

    state_t         state;
    logic [BXW-1:0] bx, bx_n;
    logic [BYW-1:0] by, by_n;
    logic           last_bx, last_by;
    logic [5:0]     fidx, fidx_n;
    logic [6:0]     issue_k;
    logic [5:0]     zz_idx;

    logic              rd_pend;
    logic [1:0]        cnt;
    logic [COEF_W:0]   slot0, slot1;
    logic [COEF_W:0]   arrival, head;
    logic [5:0]        ret_k;
    logic              pop, bypass, push;
    logic [2:0]        tokens;

    function automatic logic [ADDR_W-1:0] blk_addr(
        input int unsigned bxv,
        input int unsigned byv,
        input int unsigned i
    );
        int unsigned row;
        int unsigned col;
        row = byv * BLK + i / BLK;
        col = bxv * BLK + i % BLK;
        return ADDR_W'(row * IMG_W + col);
    endfunction

    zigzag_rom u_zz (
        .k   (issue_k[5:0]),
        .idx (zz_idx)
    );

    assign fidx_n  = fidx + 6'd1;
    assign last_bx = (bx == BXW'(BX_N - 1));
    assign last_by = (by == BYW'(BY_N - 1));

    always_comb begin
        bx_n = bx + BXW'(1);
        by_n = by;
        if (last_bx) begin
            bx_n = '0;
            by_n = by + BYW'(1);
        end
    end

    // Sample is taken straight off the memory return bus in the load cycle.
    assign dct_sample = dct_load ? ({1'b0, mem_data} - MID) : '0;

    // Output side: FIFO head, or the word arriving this cycle when empty.
    assign arrival   = {ret_k == 6'd63, coef_data};
    assign head      = (cnt != 2'd0) ? slot0 : (rd_pend ? arrival : '0);
    assign out_valid = (cnt != 2'd0) || rd_pend;
    assign out_data  = head[COEF_W-1:0];
    assign out_last  = head[COEF_W];

    assign pop    = out_valid && out_ready;
    assign bypass = pop && (cnt == 2'd0);
    assign push   = rd_pend && !bypass;
    assign tokens = 3'(cnt) + 3'(rd_pend) + 3'(coef_rd) - 3'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend <= 1'b0;
            cnt     <= '0;
            ret_k   <= '0;
            slot0   <= '0;
            slot1   <= '0;
        end else begin
            rd_pend <= coef_rd;
            if (rd_pend)
                ret_k <= ret_k + 6'd1;
            if (pop && cnt == 2'd2)
                slot0 <= slot1;
            if (push) begin
                if (cnt == 2'd0 || (cnt == 2'd1 && pop))
                    slot0 <= arrival;
                else
                    slot1 <= arrival;
            end
            cnt <= cnt + 2'(push) - 2'(pop && !bypass);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bx           <= '0;
            by           <= '0;
            fidx         <= '0;
            issue_k      <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            mem_rd       <= 1'b0;
            mem_addr     <= '0;
            dct_load     <= 1'b0;
            dct_load_idx <= '0;
            dct_start    <= 1'b0;
            coef_rd      <= 1'b0;
            coef_idx     <= '0;
        end else begin
            frame_done <= 1'b0;
            dct_load   <= mem_rd;
            if (mem_rd)
                dct_load_idx <= fidx;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        busy     <= 1'b1;
                        bx       <= '0;
                        by       <= '0;
                        fidx     <= '0;
                        issue_k  <= '0;
                        mem_rd   <= 1'b1;
                        mem_addr <= blk_addr(0, 0, 0);
                    end
                end
                FETCH: begin
                    if (fidx == 6'd63) begin
                        mem_rd <= 1'b0;
                        state  <= TAIL;
                    end else begin
                        fidx     <= fidx_n;
                        mem_addr <= blk_addr(32'(bx), 32'(by), 32'(fidx_n));
                    end
                end
                TAIL: begin
                    dct_start <= 1'b1;
                    state     <= KICK;
                end
                KICK: begin
                    dct_start <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (dct_done) begin
                        state    <= DRAIN;
                        coef_rd  <= 1'b1;
                        coef_idx <= zz_idx;
                        issue_k  <= 7'd1;
                    end
                end
                DRAIN: begin
                    // Issue only if the word will have a FIFO slot on return.
                    if (issue_k < 7'd64 && tokens < 3'd2) begin
                        coef_rd  <= 1'b1;
                        coef_idx <= zz_idx;
                        issue_k  <= issue_k + 7'd1;
                    end else begin
                        coef_rd <= 1'b0;
                    end
                    if (pop && out_last)
                        state <= NEXT;
                end
                NEXT: begin
                    issue_k <= '0;
                    fidx    <= '0;
                    bx      <= bx_n;
                    by      <= by_n;
                    if (last_bx && last_by) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        state    <= FETCH;
                        mem_rd   <= 1'b1;
                        mem_addr <= blk_addr(32'(bx_n), 32'(by_n), 0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dct_block_sequencer.sv
// Bench for dct_block_sequencer on a 16x16 image with a mock memory
// and mock DCT; streams are checked against a raster/zig-zag model.
module tb_dct_block_sequencer;

    localparam int W    = 16;
    localparam int H    = 16;
    localparam int AW   = 16;
    localparam int PW   = 8;
    localparam int CW   = 12;
    localparam int NBLK = (W / 8) * (H / 8);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, frame_done, mem_rd, dct_load, dct_start, coef_rd;
    logic out_valid, out_last;
    logic out_ready = 1'b1;
    logic dct_done = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [PW-1:0] mem_data = '0;
    logic [5:0] dct_load_idx, coef_idx;
    logic signed [PW:0] dct_sample;
    logic signed [CW-1:0] coef_data = '0;
    logic signed [CW-1:0] out_data;

    always #5 clk = ~clk;

    dct_block_sequencer #(
        .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PIX_W(PW), .COEF_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .frame_done(frame_done), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_data(mem_data), .dct_load(dct_load),
        .dct_load_idx(dct_load_idx), .dct_sample(dct_sample),
        .dct_start(dct_start), .dct_done(dct_done), .coef_rd(coef_rd),
        .coef_idx(coef_idx), .coef_data(coef_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pixel memory and mock DCT (coef[i] = loaded sample[i] + 16*i).
    logic [7:0] img [256];
    logic signed [8:0] dbuf [64];
    int cd = 0;
    int spur_req = 0, spur_ack = 0;
    always @(posedge clk) begin
        if (mem_rd) mem_data <= img[mem_addr[7:0]];
        if (dct_load) dbuf[dct_load_idx] <= dct_sample;
        if (coef_rd) coef_data <= CW'(dbuf[coef_idx]) + CW'({coef_idx, 4'b0});
        if (dct_start) cd <= 5;
        else if (cd != 0) cd <= cd - 1;
        dct_done <= (cd == 1) || (spur_req != spur_ack);
        if (spur_req != spur_ack) spur_ack <= spur_req;
    end

    int rmode = 0;
    int pat = 0;
    always @(posedge clk) begin
        #1;
        case (rmode)
            1: begin out_ready = (pat == 0 || pat == 3); pat = (pat + 1) % 4; end
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
        endcase
    end

    // Observation side
    logic [15:0] rd_q [$];
    logic [14:0] ld_q [$];
    logic [12:0] out_q [$];
    int n_done, n_kick, n_crd, n_acc, max_tok, stall_bad;
    int t_rd, t_ld, t_busy, t_kick, t_done, t_crd, t_ov, t_fd;
    bit stalled;
    logic signed [CW-1:0] prev_d;
    logic prev_l;
    int clr_req = 0, clr_ack = -1;

    always @(negedge clk) begin
        if (clr_req != clr_ack) begin
            clr_ack = clr_req;
            rd_q.delete(); ld_q.delete(); out_q.delete();
            n_done = 0; n_kick = 0; n_crd = 0; n_acc = 0;
            max_tok = 0; stall_bad = 0; stalled = 0;
            t_rd = -1; t_ld = -1; t_busy = -1; t_kick = -1;
            t_done = -1; t_crd = -1; t_ov = -1; t_fd = -1;
        end
        if (mem_rd) rd_q.push_back(mem_addr);
        if (dct_load) ld_q.push_back({dct_load_idx, dct_sample});
        if (mem_rd && t_rd < 0) t_rd = cyc;
        if (dct_load && t_ld < 0) t_ld = cyc;
        if (busy && t_busy < 0) t_busy = cyc;
        if (dct_start) begin n_kick++; if (t_kick < 0) t_kick = cyc; end
        if (dct_done && t_done < 0) t_done = cyc;
        if (coef_rd) begin n_crd++; if (t_crd < 0) t_crd = cyc; end
        if (out_valid && t_ov < 0) t_ov = cyc;
        if (out_valid && out_ready) begin
            out_q.push_back({out_last, out_data});
            n_acc++;
        end
        if (n_crd - n_acc > max_tok) max_tok = n_crd - n_acc;
        if (stalled && (!out_valid || out_data !== prev_d || out_last !== prev_l))
            stall_bad++;
        stalled = out_valid && !out_ready;
        prev_d = out_data;
        prev_l = out_last;
        if (frame_done) begin n_done++; if (t_fd < 0) t_fd = cyc; end
    end

    // Reference model
    int zz_ref [64];
    logic [15:0] exp_rd [$];
    logic [14:0] exp_ld [$];
    logic [12:0] exp_out [$];

    task automatic build_zz();
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0)
                for (int r = hi; r >= lo; r--) begin zz_ref[k] = r * 8 + (s - r); k++; end
            else
                for (int r = lo; r <= hi; r++) begin zz_ref[k] = r * 8 + (s - r); k++; end
        end
    endtask

    function automatic int pix_addr(int b, int i);
        return ((b / (W / 8)) * 8 + i / 8) * W + (b % (W / 8)) * 8 + i % 8;
    endfunction

    task automatic new_image();
        for (int a = 0; a < 256; a++) img[a] = 8'($urandom);
        exp_rd.delete(); exp_ld.delete(); exp_out.delete();
        for (int b = 0; b < NBLK; b++) begin
            for (int i = 0; i < 64; i++) begin
                exp_rd.push_back(16'(pix_addr(b, i)));
                exp_ld.push_back({6'(i), 9'(int'(img[pix_addr(b, i)]) - 128)});
            end
            for (int k = 0; k < 64; k++) begin
                int i = zz_ref[k];
                int c = int'(img[pix_addr(b, i)]) - 128 + 16 * i;
                exp_out.push_back({k == 63, 12'(c)});
            end
        end
    endtask

    function automatic int diff_rd();
        int n = (rd_q.size() < exp_rd.size()) ? rd_q.size() : exp_rd.size();
        for (int i = 0; i < n; i++) if (rd_q[i] !== exp_rd[i]) return i;
        return (rd_q.size() == exp_rd.size()) ? -1 : n;
    endfunction

    function automatic int diff_ld();
        int n = (ld_q.size() < exp_ld.size()) ? ld_q.size() : exp_ld.size();
        for (int i = 0; i < n; i++) if (ld_q[i] !== exp_ld[i]) return i;
        return (ld_q.size() == exp_ld.size()) ? -1 : n;
    endfunction

    function automatic int diff_out();
        int n = (out_q.size() < exp_out.size()) ? out_q.size() : exp_out.size();
        for (int i = 0; i < n; i++) if (out_q[i] !== exp_out[i]) return i;
        return (out_q.size() == exp_out.size()) ? -1 : n;
    endfunction

    task automatic clear_obs();
        clr_req++;
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(output int t0);
        @(posedge clk);
        #1;
        t0 = cyc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            #1;
            if (n_done > 0) begin ok = 1; break; end
        end
    endtask

    int base_len = -1;

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %b want 0", frame_done); end
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL rst_mem_rd got %b want 0", mem_rd); end
        checks++; if (dct_load !== 1'b0) begin errors++; $display("FAIL rst_dct_load got %b want 0", dct_load); end
        checks++; if (dct_start !== 1'b0) begin errors++; $display("FAIL rst_dct_start got %b want 0", dct_start); end
        checks++; if (coef_rd !== 1'b0) begin errors++; $display("FAIL rst_coef_rd got %b want 0", coef_rd); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b want 0", out_last); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL rst_mem_addr got %0d want 0", mem_addr); end
        checks++; if (dct_load_idx !== '0) begin errors++; $display("FAIL rst_load_idx got %0d want 0", dct_load_idx); end
        checks++; if (dct_sample !== '0) begin errors++; $display("FAIL rst_sample got %0d want 0", dct_sample); end
        checks++; if (coef_idx !== '0) begin errors++; $display("FAIL rst_coef_idx got %0d want 0", coef_idx); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data got %0d want 0", out_data); end
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_baseline();
        int t0, d, a1, a2, lasts;
        bit ok;
        rmode = 0;
        new_image();
        clear_obs();
        pulse_start(t0);
        wait_done(4000, ok);
        repeat (10) @(negedge clk);
        #1;
        checks++; if (!ok) begin errors++; $display("FAIL base_timeout got no frame_done want 1"); end
        d = diff_rd();
        checks++; if (d != -1) begin errors++; $display("FAIL base_reads first diff %0d got %0d reads want %0d", d, rd_q.size(), exp_rd.size()); end
        d = diff_ld();
        checks++; if (d != -1) begin errors++; $display("FAIL base_loads first diff %0d got %0d loads want %0d", d, ld_q.size(), exp_ld.size()); end
        d = diff_out();
        checks++; if (d != -1) begin errors++; $display("FAIL base_out first diff %0d got %0d words want %0d", d, out_q.size(), exp_out.size()); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL base_done_count got %0d want 1", n_done); end
        checks++; if (n_kick != NBLK) begin errors++; $display("FAIL base_kicks got %0d want %0d", n_kick, NBLK); end
        checks++; if (t_busy != t0 + 1) begin errors++; $display("FAIL base_busy_cyc got %0d want %0d", t_busy, t0 + 1); end
        checks++; if (t_rd != t0 + 1) begin errors++; $display("FAIL base_first_rd got %0d want %0d", t_rd, t0 + 1); end
        checks++; if (t_ld != t0 + 2) begin errors++; $display("FAIL base_first_load got %0d want %0d", t_ld, t0 + 2); end
        checks++; if (t_kick != t0 + 66) begin errors++; $display("FAIL base_dct_start got %0d want %0d", t_kick, t0 + 66); end
        checks++; if (t_crd != t_done + 1) begin errors++; $display("FAIL base_first_coef_rd got %0d want %0d", t_crd, t_done + 1); end
        checks++; if (t_ov != t_done + 2) begin errors++; $display("FAIL base_first_valid got %0d want %0d", t_ov, t_done + 2); end
        a1 = (rd_q.size() > 200) ? int'(rd_q[192]) : -1;
        a2 = (rd_q.size() > 200) ? int'(rd_q[200]) : -1;
        checks++; if (a1 != 136) begin errors++; $display("FAIL base_blk11_addr got %0d want 136", a1); end
        checks++; if (a2 != 152) begin errors++; $display("FAIL base_blk11_row1 got %0d want 152", a2); end
        lasts = 0;
        foreach (out_q[i]) if (out_q[i][12]) lasts++;
        checks++; if (lasts != NBLK) begin errors++; $display("FAIL base_last_count got %0d want %0d", lasts, NBLK); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL base_busy_after got %b want 0", busy); end
        base_len = t_fd - t0;
    endtask

    task automatic test_ready(input int mode);
        int t0, d;
        bit ok;
        rmode = mode;
        new_image();
        clear_obs();
        pulse_start(t0);
        wait_done(8000, ok);
        rmode = 0;
        repeat (5) @(negedge clk);
        #1;
        checks++; if (!ok) begin errors++; $display("FAIL bp%0d_timeout got no frame_done want 1", mode); end
        d = diff_out();
        checks++; if (d != -1) begin errors++; $display("FAIL bp%0d_out first diff %0d got %0d words want %0d", mode, d, out_q.size(), exp_out.size()); end
        d = diff_ld();
        checks++; if (d != -1) begin errors++; $display("FAIL bp%0d_loads first diff %0d got %0d want %0d", mode, d, ld_q.size(), exp_ld.size()); end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp%0d_stall_stable got %0d changes want 0", mode, stall_bad); end
        checks++; if (max_tok > 2) begin errors++; $display("FAIL bp%0d_occupancy got %0d want <=2", mode, max_tok); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL bp%0d_done_count got %0d want 1", mode, n_done); end
    endtask

    task automatic test_spurious();
        int t0, d;
        bit ok, st_sent, sp_sent;
        rmode = 0;
        new_image();
        clear_obs();
        pulse_start(t0);
        ok = 0; st_sent = 0; sp_sent = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            #1;
            start = (!st_sent && n_kick == 1 && cyc == t_kick + 2);
            if (start) st_sent = 1;
            if (ld_q.size() == 10 && !sp_sent) begin spur_req++; sp_sent = 1; end
            if (n_done > 0) begin ok = 1; break; end
        end
        start = 1'b0;
        repeat (200) @(negedge clk);
        #1;
        checks++; if (!ok) begin errors++; $display("FAIL spur_timeout got no frame_done want 1"); end
        d = diff_rd();
        checks++; if (d != -1) begin errors++; $display("FAIL spur_reads first diff %0d got %0d want %0d", d, rd_q.size(), exp_rd.size()); end
        d = diff_out();
        checks++; if (d != -1) begin errors++; $display("FAIL spur_out first diff %0d got %0d want %0d", d, out_q.size(), exp_out.size()); end
        checks++; if (n_kick != NBLK) begin errors++; $display("FAIL spur_kicks got %0d want %0d", n_kick, NBLK); end
        checks++; if (t_fd - t0 != base_len) begin errors++; $display("FAIL spur_frame_len got %0d want %0d", t_fd - t0, base_len); end
        checks++; if (n_done != 1 || busy !== 1'b0) begin errors++; $display("FAIL spur_no_requeue got done=%0d busy=%b want 1 0", n_done, busy); end
    endtask

    task automatic test_mid_reset();
        int t0, d;
        bit ok;
        logic [63:0] obs;
        rmode = 0;
        new_image();
        clear_obs();
        pulse_start(t0);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            if (ld_q.size() >= 158) break;
        end
        checks++; if (ld_q.size() != 158) begin errors++; $display("FAIL mrst_trigger got %0d loads want 158", ld_q.size()); end
        rst = 1'b1;
        @(negedge clk);
        obs = {busy, frame_done, mem_rd, dct_load, dct_start, coef_rd,
               out_valid, out_last, mem_addr, dct_sample, out_data,
               dct_load_idx, coef_idx};
        checks++; if (obs !== '0) begin errors++; $display("FAIL mrst_outputs got %h want 0", obs); end
        #1;
        rst = 1'b0;
        clear_obs();
        repeat (40) @(negedge clk);
        #1;
        checks++; if (ld_q.size() != 0 || out_q.size() != 0 || n_done != 0) begin
            errors++; $display("FAIL mrst_quiet got loads=%0d outs=%0d done=%0d want 0 0 0", ld_q.size(), out_q.size(), n_done);
        end
        clear_obs();
        pulse_start(t0);
        wait_done(4000, ok);
        repeat (5) @(negedge clk);
        #1;
        checks++; if (!ok) begin errors++; $display("FAIL mrst_timeout got no frame_done want 1"); end
        d = (rd_q.size() > 0) ? int'(rd_q[0]) : -1;
        checks++; if (d != 0) begin errors++; $display("FAIL mrst_first_addr got %0d want 0", d); end
        d = diff_ld();
        checks++; if (d != -1) begin errors++; $display("FAIL mrst_loads first diff %0d got %0d want %0d", d, ld_q.size(), exp_ld.size()); end
        d = diff_out();
        checks++; if (d != -1) begin errors++; $display("FAIL mrst_out first diff %0d got %0d want %0d", d, out_q.size(), exp_out.size()); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL mrst_done_count got %0d want 1", n_done); end
    endtask

    initial begin
        build_zz();
        test_reset();
        test_baseline();
        test_ready(1);
        test_ready(2);
        test_spurious();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
